// File: rtl/core65_pkg.sv
// Shared definitions for the 65C02 core register datapath: the register
// operation encoding and default sizes used by the A/X/Y register instances.
package core65_pkg;

    localparam int REG_OP_W          = 4;
    localparam int DEFAULT_REG_WIDTH = 8;

    typedef enum logic [REG_OP_W-1:0] {
        NOP      = 4'd0,
        LOAD_DB  = 4'd1,
        LOAD_ALU = 4'd2,
        INC      = 4'd3,
        DEC      = 4'd4,
        ASL      = 4'd5,
        LSR      = 4'd6,
        ROL      = 4'd7,
        ROR      = 4'd8,
        CLR      = 4'd9
    } reg_op_t;

    // True for the shift/rotate group, the only operations that touch carry.
    function automatic logic op_writes_carry(input reg_op_t op);
        return (op == ASL) || (op == LSR) || (op == ROL) || (op == ROR);
    endfunction

endpackage

// File: rtl/register_unit_n_if.sv
// Bus bundle between a general-purpose register and the surrounding core:
// operation/data inputs from the control and data paths, value and flags out.
interface register_unit_n_if
    import core65_pkg::*;
#(
    parameter int WIDTH        = DEFAULT_REG_WIDTH,
    parameter int SHADOW_DEPTH = 2,
    localparam int LVL_W       = $clog2(SHADOW_DEPTH + 1)
);
    reg_op_t            op;
    logic [WIDTH-1:0]   db_in;
    logic [WIDTH-1:0]   alu_in;
    logic               c_in;
    logic               save;
    logic               restore;

    logic [WIDTH-1:0]   data_out;
    logic               n_out;
    logic               z_out;
    logic               c_out;
    logic               c_we;
    logic [LVL_W-1:0]   shadow_level;
    logic               overflow_err;
    logic               underflow_err;

    // Control/data side that drives the register.
    modport master (
        output op, db_in, alu_in, c_in, save, restore,
        input  data_out, n_out, z_out, c_out, c_we,
               shadow_level, overflow_err, underflow_err
    );

    // The register itself.
    modport slave (
        input  op, db_in, alu_in, c_in, save, restore,
        output data_out, n_out, z_out, c_out, c_we,
               shadow_level, overflow_err, underflow_err
    );

endinterface

// File: rtl/register_shadow_stack.sv
// LIFO shadow stack holding saved register values. Entry 0 is always the
// top of stack, so push/pop are plain shifts and no pointer indexing is needed.
// A simultaneous push and pop performs the pop only.
module register_shadow_stack #(
    parameter int WIDTH  = 8,
    parameter int DEPTH  = 2,
    localparam int LVL_W = $clog2(DEPTH + 1)
) (
    input  logic             fclk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] push_data,
    output logic [WIDTH-1:0] top_data,
    output logic [LVL_W-1:0] level,
    output logic             full,
    output logic             empty
);

    localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);
    localparam logic [LVL_W-1:0] ONE_LVL  = LVL_W'(1);

    logic [WIDTH-1:0] stk_q [DEPTH];
    logic [LVL_W-1:0] level_q, level_d;
    logic             do_push, do_pop;

    assign full     = (level_q == FULL_LVL);
    assign empty    = (level_q == '0);
    assign do_pop   = pop && !empty;
    assign do_push  = push && !pop && !full;
    assign top_data = stk_q[0];
    assign level    = level_q;

    // Occupancy count follows the accepted push/pop.
    always_comb begin
        level_d = level_q;
        if (do_pop)
            level_d = level_q - ONE_LVL;
        else if (do_push)
            level_d = level_q + ONE_LVL;
    end

    // Level register; reset empties the stack.
    always_ff @(posedge fclk) begin
        if (reset)
            level_q <= '0;
        else
            level_q <= level_d;
    end

    // Entry storage shifts down on push and up on pop.
    // NOTE: storage has no reset; level_q alone decides which entries are
    // valid, so clearing the array would only cost reset fan-out.
    always_ff @(posedge fclk) begin
        if (do_push) begin
            stk_q[0] <= push_data;
            for (int i = 1; i < DEPTH; i++)
                stk_q[i] <= stk_q[i-1];
        end else if (do_pop) begin
            for (int i = 0; i < DEPTH - 1; i++)
                stk_q[i] <= stk_q[i+1];
        end
    end

endmodule

// File: rtl/register_unit_n.sv
// General-purpose data register (A/X/Y) for the 65C02 core: encoded load,
// increment/decrement and shift/rotate operations, registered carry with a
// one-cycle write strobe, combinational N/Z, and a shadow stack for
// save/restore with sticky overflow/underflow flags.
module register_unit_n
    import core65_pkg::*;
#(
    parameter int WIDTH        = DEFAULT_REG_WIDTH,
    parameter int SHADOW_DEPTH = 2,
    localparam int LVL_W       = $clog2(SHADOW_DEPTH + 1)
) (
    input  logic              fclk,
    input  logic              reset,
    register_unit_n_if.slave  bus
);

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    logic [WIDTH-1:0] data_q, data_d;
    logic             c_q, c_d;
    logic             c_we_q, c_we_d;
    logic             ovf_q, ovf_d;
    logic             unf_q, unf_d;

    logic [WIDTH-1:0] stk_top;
    logic [LVL_W-1:0] stk_level;
    logic             stk_full, stk_empty;

    // The saved value is always the pre-operation register contents; restore
    // has priority, so a save issued together with it never reaches the stack.
    register_shadow_stack #(
        .WIDTH (WIDTH),
        .DEPTH (SHADOW_DEPTH)
    ) u_shadow (
        .fclk      (fclk),
        .reset     (reset),
        .push      (bus.save && !bus.restore),
        .pop       (bus.restore),
        .push_data (data_q),
        .top_data  (stk_top),
        .level     (stk_level),
        .full      (stk_full),
        .empty     (stk_empty)
    );

    // Next register value, carry and error flags from restore/save/op.
    // NOTE: every signal this block writes gets a default first, so no path
    // through the case/if tree can leave one unassigned and infer a latch.
    always_comb begin
        data_d = data_q;
        c_d    = c_q;
        c_we_d = 1'b0;
        ovf_d  = ovf_q;
        unf_d  = unf_q;

        if (bus.restore) begin
            // Restore overrides the opcode entirely.
            if (stk_empty)
                unf_d = 1'b1;
            else
                data_d = stk_top;
        end else begin
            if (bus.save && stk_full)
                ovf_d = 1'b1;

            c_we_d = op_writes_carry(bus.op);

            case (bus.op)
                LOAD_DB:  data_d = bus.db_in;
                LOAD_ALU: data_d = bus.alu_in;
                INC:      data_d = data_q + ONE;
                DEC:      data_d = data_q - ONE;
                ASL: begin
                    data_d = {data_q[WIDTH-2:0], 1'b0};
                    c_d    = data_q[WIDTH-1];
                end
                LSR: begin
                    data_d = {1'b0, data_q[WIDTH-1:1]};
                    c_d    = data_q[0];
                end
                ROL: begin
                    data_d = {data_q[WIDTH-2:0], bus.c_in};
                    c_d    = data_q[WIDTH-1];
                end
                ROR: begin
                    data_d = {bus.c_in, data_q[WIDTH-1:1]};
                    c_d    = data_q[0];
                end
                CLR:      data_d = '0;
                default:  data_d = data_q;   // NOP and unused codes hold
            endcase
        end
    end

    // Architectural state update; reset overrides all inputs.
    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge fclk) begin
        if (reset) begin
            data_q <= '0;
            c_q    <= 1'b0;
            c_we_q <= 1'b0;
            ovf_q  <= 1'b0;
            unf_q  <= 1'b0;
        end else begin
            data_q <= data_d;
            c_q    <= c_d;
            c_we_q <= c_we_d;
            ovf_q  <= ovf_d;
            unf_q  <= unf_d;
        end
    end

    assign bus.data_out      = data_q;
    assign bus.n_out         = data_q[WIDTH-1];
    assign bus.z_out         = (data_q == '0);
    assign bus.c_out         = c_q;
    assign bus.c_we          = c_we_q;
    assign bus.shadow_level  = stk_level;
    assign bus.overflow_err  = ovf_q;
    assign bus.underflow_err = unf_q;

endmodule

// File: tb/tb_register_unit_n.sv
// Self-checking bench for register_unit_n (WIDTH=8, SHADOW_DEPTH=2).
// A behavioural model (integer value, queue as the shadow stack) is updated
// after every clock edge; a compare process checks all outputs mid-cycle,
// and hand-computed literals pin the model at key points.
module tb_register_unit_n;
    import core65_pkg::*;

    localparam int W     = 8;
    localparam int DEPTH = 2;
    localparam int MOD   = 1 << W;

    logic fclk;
    logic reset;

    register_unit_n_if #(.WIDTH(W), .SHADOW_DEPTH(DEPTH)) bus ();

    register_unit_n #(.WIDTH(W), .SHADOW_DEPTH(DEPTH)) dut (
        .fclk  (fclk),
        .reset (reset),
        .bus   (bus)
    );

    initial fclk = 1'b0;
    always #5 fclk = ~fclk;

    int n_vec = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    // Model state.
    int m_val;
    int m_c;
    int m_cwe;
    int m_of;
    int m_uf;
    int m_stk[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // One clock of register behaviour, written from the operation rules.
    task automatic model_update(input int op, input int db, input int alu,
                                input int cin, input bit sv, input bit rs, input bit rst);
        if (rst) begin
            m_val = 0; m_c = 0; m_cwe = 0; m_of = 0; m_uf = 0;
            m_stk.delete();
            return;
        end
        m_cwe = 0;
        if (rs) begin
            if (m_stk.size() > 0) m_val = m_stk.pop_back();
            else                  m_uf  = 1;
        end else begin
            if (sv) begin
                if (m_stk.size() < DEPTH) m_stk.push_back(m_val);
                else                      m_of = 1;
            end
            case (op)
                1: m_val = db;
                2: m_val = alu;
                3: m_val = (m_val + 1) % MOD;
                4: m_val = (m_val + MOD - 1) % MOD;
                5: begin m_c = m_val / (MOD/2); m_val = (m_val * 2) % MOD;               m_cwe = 1; end
                6: begin m_c = m_val % 2;       m_val = m_val / 2;                       m_cwe = 1; end
                7: begin m_c = m_val / (MOD/2); m_val = (m_val * 2) % MOD + cin;         m_cwe = 1; end
                8: begin m_c = m_val % 2;       m_val = m_val / 2 + cin * (MOD/2);       m_cwe = 1; end
                9: m_val = 0;
                default: ;
            endcase
        end
    endtask

    // Drive one cycle of inputs, let the edge happen, advance the model.
    task automatic step(input logic [3:0] op, input logic [7:0] db = 8'h00,
                        input bit sv = 1'b0, input bit rs = 1'b0,
                        input bit cin = 1'b0, input logic [7:0] alu = 8'h00,
                        input bit rst = 1'b0);
        bus.op      = reg_op_t'(op);
        bus.db_in   = db;
        bus.alu_in  = alu;
        bus.c_in    = cin;
        bus.save    = sv;
        bus.restore = rs;
        reset       = rst;
        @(posedge fclk);
        model_update(int'(op), int'(db), int'(alu), int'(cin), sv, rs, rst);
        #1;
    endtask

    // Every cycle after reset: all outputs against the model.
    always @(negedge fclk) begin
        if (chk_en) begin
            check("data_out",      32'(bus.data_out),      32'(m_val));
            check("n_out",         32'(bus.n_out),         32'(m_val / (MOD/2)));
            check("z_out",         32'(bus.z_out),         32'(m_val == 0));
            check("c_out",         32'(bus.c_out),         32'(m_c));
            check("c_we",          32'(bus.c_we),          32'(m_cwe));
            check("shadow_level",  32'(bus.shadow_level),  32'(m_stk.size()));
            check("overflow_err",  32'(bus.overflow_err),  32'(m_of));
            check("underflow_err", 32'(bus.underflow_err), 32'(m_uf));
        end
    end

    initial begin
        bus.op = NOP; bus.db_in = '0; bus.alu_in = '0; bus.c_in = 1'b0;
        bus.save = 1'b0; bus.restore = 1'b0; reset = 1'b1;

        // Reset then idle.
        step(NOP, .rst(1'b1));
        step(NOP, .rst(1'b1));
        chk_en = 1'b1;
        step(NOP);
        check("rst_data",  32'(bus.data_out), 32'h00);
        check("rst_z",     32'(bus.z_out),    32'h1);
        check("rst_n",     32'(bus.n_out),    32'h0);
        check("rst_c",     32'(bus.c_out),    32'h0);
        check("rst_level", 32'(bus.shadow_level), 32'h0);
        check("rst_errs",  32'({bus.overflow_err, bus.underflow_err}), 32'h0);

        // Wrap-around: INC of all-ones, DEC of zero.
        step(LOAD_DB, 8'hFF);
        step(INC);
        check("inc_wrap",   32'(bus.data_out), 32'h00);
        check("inc_wrap_z", 32'(bus.z_out),    32'h1);
        check("inc_no_cwe", 32'(bus.c_we),     32'h0);
        step(DEC);
        check("dec_wrap",   32'(bus.data_out), 32'hFF);
        check("dec_wrap_n", 32'(bus.n_out),    32'h1);

        // Shift and rotate with carry.
        step(LOAD_DB, 8'h81);
        step(ASL);
        check("asl_val", 32'(bus.data_out), 32'h02);
        check("asl_c",   32'(bus.c_out),    32'h1);
        check("asl_cwe", 32'(bus.c_we),     32'h1);
        step(ROR, .cin(1'b1));
        check("ror_val", 32'(bus.data_out), 32'h81);
        check("ror_c",   32'(bus.c_out),    32'h0);
        step(NOP);
        check("cwe_drop", 32'(bus.c_we),    32'h0);
        step(LOAD_ALU, .alu(8'hA5));
        step(LSR);
        check("lsr_val", 32'(bus.data_out), 32'h52);
        check("lsr_c",   32'(bus.c_out),    32'h1);
        step(ROL, .cin(1'b0));
        check("rol_val", 32'(bus.data_out), 32'hA4);
        check("rol_c",   32'(bus.c_out),    32'h0);
        step(LOAD_DB, 8'h5A);
        step(4'd12);
        check("unused_op_hold", 32'(bus.data_out), 32'h5A);
        step(4'd15);
        step(CLR);
        check("clr", 32'(bus.data_out), 32'h00);

        // Fill the stack, overflow, then drain and underflow.
        step(LOAD_DB, 8'h11);
        step(LOAD_DB, 8'h22, .sv(1'b1));
        step(NOP, .sv(1'b1));
        step(LOAD_DB, 8'h33, .sv(1'b1));
        check("ovf_level", 32'(bus.shadow_level), 32'h2);
        check("ovf_flag",  32'(bus.overflow_err), 32'h1);
        check("ovf_data",  32'(bus.data_out),     32'h33);
        step(ASL, .rs(1'b1));
        check("pop1", 32'(bus.data_out), 32'h22);
        check("pop1_no_cwe", 32'(bus.c_we), 32'h0);
        step(NOP, .rs(1'b1));
        check("pop2", 32'(bus.data_out), 32'h11);
        step(INC, .rs(1'b1));
        check("unf_flag", 32'(bus.underflow_err), 32'h1);
        check("unf_data", 32'(bus.data_out),      32'h11);

        // Save and restore together: pop wins, op ignored.
        step(LOAD_DB, 8'h44);
        step(NOP, .sv(1'b1));
        step(INC, .sv(1'b1), .rs(1'b1));
        check("sr_data",  32'(bus.data_out),     32'h44);
        check("sr_level", 32'(bus.shadow_level), 32'h0);
        check("sr_ovf",   32'(bus.overflow_err), 32'h1);
        step(NOP, .sv(1'b1), .rs(1'b1));
        check("sr_empty_level", 32'(bus.shadow_level), 32'h0);

        // Reset mid-sequence with one entry stacked.
        step(LOAD_DB, 8'hC3);
        step(NOP, .sv(1'b1));
        step(ROL, .cin(1'b1), .rst(1'b1));
        check("midrst_data",  32'(bus.data_out),     32'h00);
        check("midrst_level", 32'(bus.shadow_level), 32'h0);
        check("midrst_errs",  32'({bus.overflow_err, bus.underflow_err}), 32'h0);
        check("midrst_c",     32'({bus.c_out, bus.c_we}), 32'h0);
        step(NOP, .rs(1'b1));
        check("post_rst_unf", 32'(bus.underflow_err), 32'h1);
        step(NOP);

        chk_en = 1'b0;
        @(posedge fclk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
